// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS-style core.
// Contents: opcode values, FSM state encoding, ALU operation enum and
// small decode helpers used by the core.
package mips_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_JR   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  function automatic alu_op_e alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Register-register ops read q2/q1; every other op needs q2/q3.
  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 16 x XLEN register file, two asynchronous read ports, one synchronous
// write port. R0 always reads zero and ignores writes.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears all)
//   ra0_i/rd0_o         read port 0 address / data
//   ra1_i/rd1_o         read port 1 address / data
//   we_i, wa_i, wd_i    write enable, address, data
module mips_mc_regfile
  import mips_mc_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      ra0_i,
  output logic [XLEN-1:0] rd0_o,
  input  logic [3:0]      ra1_i,
  output logic [XLEN-1:0] rd1_o,
  input  logic            we_i,
  input  logic [3:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [16];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 4'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd0_o = (ra0_i == 4'd0) ? '0 : regs_q[ra0_i];
  assign rd1_o = (ra1_i == 4'd0) ? '0 : regs_q[ra1_i];

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS-style core: control FSM, ALU, PC/IR/MDR/A/B/C/ALUout
// registers and a 16-entry register file, sharing one memory port.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 start request, only looked at in IDLE
//   mem_req/mem_we      memory request / write strobe, held until mem_ready
//   mem_addr/mem_wdata  word address (PC or ALUout) / store data
//   mem_rdata/mem_ready read data / request completion
//   pc_o                architectural PC
//   halted, error       sticky status, cleared only by rst
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int                XLEN     = 16,
  parameter int                ADDR_W   = XLEN,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted,
  output logic              error
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [XLEN-1:0]   mdr_q, a_q, b_q, c_q, alu_q;
  logic [XLEN-1:0]   rd0, rd1, opa, opb, alu_res;
  logic [3:0]        op, q3, q2, q1;

  assign op = ir_q[15:12];
  assign q3 = ir_q[11:8];
  assign q2 = ir_q[7:4];
  assign q1 = ir_q[3:0];

  // Port 1 serves q1 for register-register ops and q3 otherwise, so B and C
  // are both loaded from it; each op only ever consumes the one it needs.
  mips_mc_regfile #(.XLEN(XLEN)) u_regfile (
    .clk_i (clk),
    .rst_i (rst),
    .ra0_i (q2),
    .rd0_o (rd0),
    .ra1_i (is_rtype(op) ? q1 : q3),
    .rd1_o (rd1),
    .we_i  (state_q == S_WB),
    .wa_i  (q3),
    .wd_i  ((op == OP_LW) ? mdr_q : alu_q)
  );

  always_comb begin
    opa = a_q;
    opb = b_q;
    if (op == OP_ADDI) begin
      opa = c_q;
      opb = {{(XLEN-8){ir_q[7]}}, ir_q[7:0]};
    end else if ((op == OP_LW) || (op == OP_SW)) begin
      opb = {{(XLEN-4){1'b0}}, q1};
    end
    alu_res = opa + opb;
    case (alu_op_of(op))
      ALU_SUB: alu_res = opa - opb;
      ALU_AND: alu_res = opa & opb;
      ALU_OR:  alu_res = opa | opb;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request outputs come straight from state plus registers that only
  // change on the completing cycle, so they hold steady through stalls.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_HALT)    state_d = S_HALT;
        else if (op > OP_JR)  state_d = S_ERR;
        else                  state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_LW, OP_SW:         state_d = S_MEM;
          OP_BEQ, OP_J, OP_JR:  state_d = S_FETCH;
          default:              state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = alu_q[ADDR_W-1:0];
        if (mem_ready) state_d = (op == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mdr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      alu_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (mem_ready) begin
          ir_q <= mem_rdata[15:0];
          pc_q <= pc_q + ADDR_W'(1);
        end
        S_DECODE: begin
          a_q <= rd0;
          b_q <= rd1;
          c_q <= rd1;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          // pc_q already points past this instruction.
          if ((op == OP_BEQ) && (c_q == a_q))
            pc_q <= pc_q + {{(ADDR_W-4){q1[3]}}, q1};
          else if (op == OP_J)
            pc_q <= {pc_q[ADDR_W-1:12], ir_q[11:0]};
          else if (op == OP_JR)
            pc_q <= c_q[ADDR_W-1:0];
        end
        S_MEM: if (mem_ready) mdr_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign mem_wdata = c_q;
  assign pc_o      = pc_q;
  assign halted    = (state_q == S_HALT) || (state_q == S_ERR);
  assign error     = (state_q == S_ERR);

endmodule
